// File: rtl/rstation_append_ctrl.sv
// -----------------------------------------------------------------------------
// rstation_append_ctrl
//
// Reservation-station bank of the Tomasulo core. Sits between issue and the
// functional units and holds ENTRIES instructions for each of three classes:
// ADD (add/sub), MUL (mul/div) and BCH (branches).
//
//   * Each cycle at most one issued instruction is appended to the
//     lowest-index free entry of its class. Register values are captured
//     directly, or the producing ROB tag is recorded, with a same-cycle
//     bypass from the CDB.
//   * CDB broadcasts resolve waiting operands in every busy entry.
//   * Each class offers one ready entry to its functional unit through a
//     valid/ack handshake; an acked entry is freed at the edge.
//
// Optional feature (macro RS_AGE_PRIORITY_EN):
//   defined   - dispatch picks the oldest ready entry of a class
//   undefined - dispatch picks the lowest-index ready entry; no age state
//
// Ports:
//   clk1, rst                      clock, synchronous active-high reset
//   in_valid, func, rs1, rs2, rd   issued instruction
//   rob_ind                        ROB slot of the issued instruction
//   rsN_busy, rsN_tag, rsN_val     register status / value for each source
//   append_ok                      combinational: instruction accepted
//   cdb_valid, cdb_tag, cdb_data   common data bus
//   X_valid/op/vj/vk/rob/rd, X_ack dispatch port, X in {add, mul, bch}
//   add_count, mul_count, bch_count occupied entries per class
// -----------------------------------------------------------------------------
module rstation_append_ctrl #(
   parameter int DATA_W  = 16,
   parameter int ROB_W   = 3,
   parameter int REG_W   = 4,
   parameter int ENTRIES = 2
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [3:0]        func,
   input  logic [REG_W-1:0]  rs1,
   input  logic [REG_W-1:0]  rs2,
   input  logic [REG_W-1:0]  rd,
   input  logic [ROB_W-1:0]  rob_ind,
   input  logic              rs1_busy,
   input  logic              rs2_busy,
   input  logic [ROB_W-1:0]  rs1_tag,
   input  logic [ROB_W-1:0]  rs2_tag,
   input  logic [DATA_W-1:0] rs1_val,
   input  logic [DATA_W-1:0] rs2_val,
   output logic              append_ok,
   input  logic              cdb_valid,
   input  logic [ROB_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output logic              add_valid,
   output logic [3:0]        add_op,
   output logic [DATA_W-1:0] add_vj,
   output logic [DATA_W-1:0] add_vk,
   output logic [ROB_W-1:0]  add_rob,
   output logic [REG_W-1:0]  add_rd,
   input  logic              add_ack,
   output logic              mul_valid,
   output logic [3:0]        mul_op,
   output logic [DATA_W-1:0] mul_vj,
   output logic [DATA_W-1:0] mul_vk,
   output logic [ROB_W-1:0]  mul_rob,
   output logic [REG_W-1:0]  mul_rd,
   input  logic              mul_ack,
   output logic              bch_valid,
   output logic [3:0]        bch_op,
   output logic [DATA_W-1:0] bch_vj,
   output logic [DATA_W-1:0] bch_vk,
   output logic [ROB_W-1:0]  bch_rob,
   output logic [REG_W-1:0]  bch_rd,
   input  logic              bch_ack,
   output logic [1:0]        add_count,
   output logic [1:0]        mul_count,
   output logic [1:0]        bch_count
);

   localparam int NCLS  = 3;
   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   typedef enum logic [1:0] {
      CLS_ADD = 2'd0,
      CLS_MUL = 2'd1,
      CLS_BCH = 2'd2
   } cls_e;

   typedef struct packed {
      logic              busy;
      logic [3:0]        op;
      logic [DATA_W-1:0] vj;
      logic [DATA_W-1:0] vk;
      logic [ROB_W-1:0]  qj;
      logic [ROB_W-1:0]  qk;
      logic              rj;
      logic              rk;
      logic [ROB_W-1:0]  rob;
      logic [REG_W-1:0]  rd;
   } entry_t;

   entry_t            rs_q    [NCLS][ENTRIES];
   entry_t            rs_d    [NCLS][ENTRIES];
   logic [1:0]        count_q [NCLS];
   logic [1:0]        count_d [NCLS];

   cls_e              in_cls;
   logic              in_legal;
   entry_t            new_e;
   logic              free_found [NCLS];
   logic [IDX_W-1:0]  free_idx   [NCLS];
   logic              ready      [NCLS][ENTRIES];
   logic              sel_valid  [NCLS];
   logic [IDX_W-1:0]  sel_idx    [NCLS];
   logic              ack_v      [NCLS];
   logic              disp       [NCLS];

   logic [3:0]        out_op  [NCLS];
   logic [DATA_W-1:0] out_vj  [NCLS];
   logic [DATA_W-1:0] out_vk  [NCLS];
   logic [ROB_W-1:0]  out_rob [NCLS];
   logic [REG_W-1:0]  out_rd  [NCLS];

   // Source register indices are not needed here: dependencies are carried
   // entirely by the busy/tag/value triples from register status.
   logic unused_regs;
   assign unused_regs = ^{rs1, rs2};

`ifdef RS_AGE_PRIORITY_EN
   // older_q[c][i][j] = 1 when entry i of class c was appended before entry j.
   logic older_q [NCLS][ENTRIES][ENTRIES];
   logic older_d [NCLS][ENTRIES][ENTRIES];
`endif

   // ---------------------------------------------------------------- decode
   always_comb begin
      // NOTE: every signal written here gets a value before any condition,
      // otherwise a path that skips the assignment infers a latch.
      in_legal = ~func[3];
      if (func[2])      in_cls = CLS_BCH;
      else if (func[1]) in_cls = CLS_MUL;
      else              in_cls = CLS_ADD;
   end

   assign ack_v[CLS_ADD] = add_ack;
   assign ack_v[CLS_MUL] = mul_ack;
   assign ack_v[CLS_BCH] = bch_ack;

   // Lowest free entry per class; descending scan leaves the lowest hit last.
   always_comb begin
      for (int c = 0; c < NCLS; c++) begin
         free_found[c] = 1'b0;
         free_idx[c]   = '0;
         for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (!rs_q[c][e].busy) begin
               free_found[c] = 1'b1;
               free_idx[c]   = IDX_W'(e);
            end
         end
      end
   end

   // Free state is taken before the edge, so a slot dispatched this cycle is
   // not reused until the next one.
   assign append_ok = in_valid & in_legal & free_found[in_cls];

   // New entry with operand capture and same-cycle CDB bypass.
   always_comb begin
      new_e      = '0;
      new_e.busy = 1'b1;
      new_e.op   = func;
      new_e.rob  = rob_ind;
      new_e.rd   = rd;
      new_e.qj   = rs1_tag;
      new_e.qk   = rs2_tag;
      if (!rs1_busy) begin
         new_e.vj = rs1_val;
         new_e.rj = 1'b1;
      end else if (cdb_valid && cdb_tag == rs1_tag) begin
         new_e.vj = cdb_data;
         new_e.rj = 1'b1;
      end
      if (!rs2_busy) begin
         new_e.vk = rs2_val;
         new_e.rk = 1'b1;
      end else if (cdb_valid && cdb_tag == rs2_tag) begin
         new_e.vk = cdb_data;
         new_e.rk = 1'b1;
      end
   end

   // -------------------------------------------------------------- dispatch
   always_comb begin
      for (int c = 0; c < NCLS; c++)
         for (int e = 0; e < ENTRIES; e++)
            ready[c][e] = rs_q[c][e].busy & rs_q[c][e].rj & rs_q[c][e].rk;
   end

   always_comb begin
      for (int c = 0; c < NCLS; c++) begin
         sel_valid[c] = 1'b0;
         sel_idx[c]   = '0;
         for (int e = ENTRIES - 1; e >= 0; e--) begin
`ifdef RS_AGE_PRIORITY_EN
            // Eligible only if no other ready entry is older.
            logic elig;
            elig = ready[c][e];
            for (int j = 0; j < ENTRIES; j++)
               if (j != e && ready[c][j] && older_q[c][j][e]) elig = 1'b0;
            if (elig) begin
`else
            if (ready[c][e]) begin
`endif
               sel_valid[c] = 1'b1;
               sel_idx[c]   = IDX_W'(e);
            end
         end
         disp[c] = sel_valid[c] & ack_v[c];
      end
   end

   always_comb begin
      for (int c = 0; c < NCLS; c++) begin
         out_op[c]  = '0;
         out_vj[c]  = '0;
         out_vk[c]  = '0;
         out_rob[c] = '0;
         out_rd[c]  = '0;
         if (sel_valid[c]) begin
            out_op[c]  = rs_q[c][sel_idx[c]].op;
            out_vj[c]  = rs_q[c][sel_idx[c]].vj;
            out_vk[c]  = rs_q[c][sel_idx[c]].vk;
            out_rob[c] = rs_q[c][sel_idx[c]].rob;
            out_rd[c]  = rs_q[c][sel_idx[c]].rd;
         end
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      rs_d = rs_q;
      for (int c = 0; c < NCLS; c++) begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (rs_q[c][e].busy && cdb_valid) begin
               if (!rs_q[c][e].rj && rs_q[c][e].qj == cdb_tag) begin
                  rs_d[c][e].vj = cdb_data;
                  rs_d[c][e].rj = 1'b1;
               end
               if (!rs_q[c][e].rk && rs_q[c][e].qk == cdb_tag) begin
                  rs_d[c][e].vk = cdb_data;
                  rs_d[c][e].rk = 1'b1;
               end
            end
         end
         if (disp[c]) rs_d[c][sel_idx[c]].busy = 1'b0;
         count_d[c] = count_q[c]
                    + {1'b0, append_ok && (in_cls == cls_e'(c))}
                    - {1'b0, disp[c]};
      end
      // The target entry was free before the edge, so it cannot collide with
      // the CDB or dispatch updates above.
      if (append_ok) rs_d[in_cls][free_idx[in_cls]] = new_e;
   end

`ifdef RS_AGE_PRIORITY_EN
   // A newly appended entry becomes younger than every other entry.
   always_comb begin
      older_d = older_q;
      if (append_ok) begin
         for (int j = 0; j < ENTRIES; j++) begin
            older_d[in_cls][free_idx[in_cls]][j] = 1'b0;
            if (IDX_W'(j) != free_idx[in_cls])
               older_d[in_cls][j][free_idx[in_cls]] = 1'b1;
         end
      end
   end
`endif

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk1) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         for (int c = 0; c < NCLS; c++) begin
            count_q[c] <= '0;
            // NOTE: only the control bits are reset; payload fields are never
            // observed until an append rewrites the whole entry.
            for (int e = 0; e < ENTRIES; e++) begin
               rs_q[c][e].busy <= 1'b0;
               rs_q[c][e].rj   <= 1'b0;
               rs_q[c][e].rk   <= 1'b0;
`ifdef RS_AGE_PRIORITY_EN
               for (int j = 0; j < ENTRIES; j++) older_q[c][e][j] <= 1'b0;
`endif
            end
         end
      end else begin
         for (int c = 0; c < NCLS; c++) begin
            count_q[c] <= count_d[c];
            for (int e = 0; e < ENTRIES; e++) begin
               rs_q[c][e] <= rs_d[c][e];
`ifdef RS_AGE_PRIORITY_EN
               for (int j = 0; j < ENTRIES; j++) older_q[c][e][j] <= older_d[c][e][j];
`endif
            end
         end
      end
   end

   // --------------------------------------------------------------- outputs
   assign add_valid = sel_valid[CLS_ADD];
   assign add_op    = out_op[CLS_ADD];
   assign add_vj    = out_vj[CLS_ADD];
   assign add_vk    = out_vk[CLS_ADD];
   assign add_rob   = out_rob[CLS_ADD];
   assign add_rd    = out_rd[CLS_ADD];

   assign mul_valid = sel_valid[CLS_MUL];
   assign mul_op    = out_op[CLS_MUL];
   assign mul_vj    = out_vj[CLS_MUL];
   assign mul_vk    = out_vk[CLS_MUL];
   assign mul_rob   = out_rob[CLS_MUL];
   assign mul_rd    = out_rd[CLS_MUL];

   assign bch_valid = sel_valid[CLS_BCH];
   assign bch_op    = out_op[CLS_BCH];
   assign bch_vj    = out_vj[CLS_BCH];
   assign bch_vk    = out_vk[CLS_BCH];
   assign bch_rob   = out_rob[CLS_BCH];
   assign bch_rd    = out_rd[CLS_BCH];

   assign add_count = count_q[CLS_ADD];
   assign mul_count = count_q[CLS_MUL];
   assign bch_count = count_q[CLS_BCH];

endmodule

// File: tb/tb_rstation_append_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rstation_append_ctrl
//
// Directed bench for rstation_append_ctrl: reset, append/dispatch, CDB
// resolution and bypass, full class, ack with append, illegal opcode, class
// routing and dispatch priority (expectation follows RS_AGE_PRIORITY_EN).
// -----------------------------------------------------------------------------
module tb_rstation_append_ctrl;

   logic        clk1 = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  func;
   logic [3:0]  rs1, rs2, rd;
   logic [2:0]  rob_ind;
   logic        rs1_busy, rs2_busy;
   logic [2:0]  rs1_tag, rs2_tag;
   logic [15:0] rs1_val, rs2_val;
   logic        append_ok;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic        add_valid, mul_valid, bch_valid;
   logic [3:0]  add_op, mul_op, bch_op;
   logic [15:0] add_vj, add_vk, mul_vj, mul_vk, bch_vj, bch_vk;
   logic [2:0]  add_rob, mul_rob, bch_rob;
   logic [3:0]  add_rd, mul_rd, bch_rd;
   logic        add_ack, mul_ack, bch_ack;
   logic [1:0]  add_count, mul_count, bch_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk1 = ~clk1;

   rstation_append_ctrl dut (
      .clk1(clk1), .rst(rst), .in_valid(in_valid), .func(func),
      .rs1(rs1), .rs2(rs2), .rd(rd), .rob_ind(rob_ind),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
      .rs1_val(rs1_val), .rs2_val(rs2_val),
      .append_ok(append_ok),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .add_valid(add_valid), .add_op(add_op), .add_vj(add_vj), .add_vk(add_vk),
      .add_rob(add_rob), .add_rd(add_rd), .add_ack(add_ack),
      .mul_valid(mul_valid), .mul_op(mul_op), .mul_vj(mul_vj), .mul_vk(mul_vk),
      .mul_rob(mul_rob), .mul_rd(mul_rd), .mul_ack(mul_ack),
      .bch_valid(bch_valid), .bch_op(bch_op), .bch_vj(bch_vj), .bch_vk(bch_vk),
      .bch_rob(bch_rob), .bch_rd(bch_rd), .bch_ack(bch_ack),
      .add_count(add_count), .mul_count(mul_count), .bch_count(bch_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; func = '0; rs1 = '0; rs2 = '0; rd = '0; rob_ind = '0;
      rs1_busy = 1'b0; rs2_busy = 1'b0; rs1_tag = '0; rs2_tag = '0;
      rs1_val = '0; rs2_val = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
      add_ack = 1'b0; mul_ack = 1'b0; bch_ack = 1'b0;
   endtask

   task automatic issue(input logic [3:0] f,
                        input logic b1, input logic [2:0] t1, input logic [15:0] v1,
                        input logic b2, input logic [2:0] t2, input logic [15:0] v2,
                        input logic [2:0] rob, input logic [3:0] d);
      in_valid = 1'b1; func = f; rob_ind = rob; rd = d;
      rs1_busy = b1; rs1_tag = t1; rs1_val = v1;
      rs2_busy = b2; rs2_tag = t2; rs2_val = v2;
      #1;
   endtask

   initial begin
      // Reset with an add presented: reset must win.
      idle();
      rst = 1'b1;
      issue(4'b0000, 0, 0, 16'd1, 0, 0, 16'd1, 3'd1, 4'd1);
      tick();
      rst = 1'b0;
      idle();
      #1;
      check("rst_add_count", add_count, 0);
      check("rst_mul_count", mul_count, 0);
      check("rst_bch_count", bch_count, 0);
      check("rst_add_valid", add_valid, 0);
      check("rst_mul_valid", mul_valid, 0);
      check("rst_bch_valid", bch_valid, 0);
      check("rst_add_vj", add_vj, 0);
      check("rst_add_rob", add_rob, 0);

      // Simple add, dispatch on the cycle after the append.
      issue(4'b0000, 0, 0, 16'd5, 0, 0, 16'd7, 3'd3, 4'd2);
      check("add_append_ok", append_ok, 1);
      tick();
      idle();
      check("add_valid", add_valid, 1);
      check("add_op", add_op, 4'b0000);
      check("add_vj", add_vj, 16'd5);
      check("add_vk", add_vk, 16'd7);
      check("add_rob", add_rob, 3'd3);
      check("add_rd", add_rd, 4'd2);
      check("add_count_1", add_count, 1);
      add_ack = 1'b1;
      tick();
      idle();
      check("add_count_after_ack", add_count, 0);
      check("add_valid_after_ack", add_valid, 0);

      // Mul waiting on tag 4 for both operands.
      issue(4'b0010, 1, 3'd4, 16'd0, 1, 3'd4, 16'd0, 3'd5, 4'd6);
      check("mul_append_ok", append_ok, 1);
      tick();
      idle();
      check("mul_count_1", mul_count, 1);
      check("mul_waiting", mul_valid, 0);
      cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h1234;
      tick();
      idle();
      check("mul_wrong_tag", mul_valid, 0);
      cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h00AA;
      #1;
      check("mul_before_cdb_edge", mul_valid, 0);
      tick();
      idle();
      check("mul_valid_after_cdb", mul_valid, 1);
      check("mul_vj_cdb", mul_vj, 16'h00AA);
      check("mul_vk_cdb", mul_vk, 16'h00AA);
      check("mul_rob", mul_rob, 3'd5);
      mul_ack = 1'b1;
      tick();
      idle();
      check("mul_count_0", mul_count, 0);

      // Div with same-cycle CDB bypass on rs1.
      cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h0055;
      issue(4'b0011, 1, 3'd4, 16'd0, 0, 0, 16'h0077, 3'd2, 4'd9);
      check("div_append_ok", append_ok, 1);
      tick();
      idle();
      check("div_bypass_valid", mul_valid, 1);
      check("div_op", mul_op, 4'b0011);
      check("div_vj", mul_vj, 16'h0055);
      check("div_vk", mul_vk, 16'h0077);
      mul_ack = 1'b1;
      tick();
      idle();
      check("div_count_0", mul_count, 0);

      // Fill the ADD class, third append refused.
      issue(4'b0000, 0, 0, 16'd1, 0, 0, 16'd2, 3'd0, 4'd1);
      check("fill_a_ok", append_ok, 1);
      tick();
      issue(4'b0001, 0, 0, 16'd3, 0, 0, 16'd4, 3'd1, 4'd3);
      check("fill_b_ok", append_ok, 1);
      tick();
      issue(4'b0000, 0, 0, 16'd5, 0, 0, 16'd6, 3'd2, 4'd4);
      check("fill_c_refused", append_ok, 0);
      tick();
      idle();
      check("full_count", add_count, 2);
      check("full_sel_entry0", add_vj, 16'd1);
      // Ack plus append while full: freed slot is not reused this cycle.
      add_ack = 1'b1;
      issue(4'b0000, 0, 0, 16'd9, 0, 0, 16'd8, 3'd6, 4'd7);
      check("ack_append_refused", append_ok, 0);
      tick();
      idle();
      check("ack_append_count", add_count, 1);
      check("ack_append_sel", add_vj, 16'd3);
      // Re-present: lands in freed entry0, appended after entry1.
      issue(4'b0000, 0, 0, 16'd9, 0, 0, 16'd8, 3'd6, 4'd7);
      check("reappend_ok", append_ok, 1);
      tick();
      idle();
      check("reappend_count", add_count, 2);
`ifdef RS_AGE_PRIORITY_EN
      check("age_order_vj", add_vj, 16'd3);
      check("age_order_rob", add_rob, 3'd1);
`else
      check("age_order_vj", add_vj, 16'd9);
      check("age_order_rob", add_rob, 3'd6);
`endif
      add_ack = 1'b1;
      tick();
      idle();
      check("after_first_dispatch", add_count, 1);
`ifdef RS_AGE_PRIORITY_EN
      check("remaining_vj", add_vj, 16'd9);
`else
      check("remaining_vj", add_vj, 16'd3);
`endif
      // Ack plus append with a free slot: net count change 0.
      add_ack = 1'b1;
      issue(4'b0001, 0, 0, 16'd11, 0, 0, 16'd12, 3'd7, 4'd5);
      check("net0_append_ok", append_ok, 1);
      tick();
      idle();
      check("net0_count", add_count, 1);
      check("net0_vj", add_vj, 16'd11);
      check("net0_op", add_op, 4'b0001);
      add_ack = 1'b1;
      tick();
      idle();
      check("drain_count", add_count, 0);
      check("drain_valid", add_valid, 0);

      // Illegal opcode dropped, branch routed to BCH only.
      issue(4'b1000, 0, 0, 16'd1, 0, 0, 16'd1, 3'd1, 4'd1);
      check("illegal_refused", append_ok, 0);
      tick();
      idle();
      check("illegal_add_count", add_count, 0);
      check("illegal_mul_count", mul_count, 0);
      check("illegal_bch_count", bch_count, 0);
      issue(4'b0101, 0, 0, 16'h0010, 0, 0, 16'h0020, 3'd1, 4'd0);
      check("bch_append_ok", append_ok, 1);
      tick();
      idle();
      check("bch_count_1", bch_count, 1);
      check("bch_add_count", add_count, 0);
      check("bch_mul_count", mul_count, 0);
      check("bch_valid", bch_valid, 1);
      check("bch_op", bch_op, 4'b0101);
      check("bch_vk", bch_vk, 16'h0020);
      check("bch_not_add", add_valid, 0);
      // Acks on idle classes are ignored.
      add_ack = 1'b1; mul_ack = 1'b1; bch_ack = 1'b1;
      tick();
      idle();
      check("bch_count_0", bch_count, 0);
      check("idle_ack_add_count", add_count, 0);
      check("idle_ack_mul_count", mul_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
